// File: rtl/prog_mem_arb_pkg.sv
// Shared types and helpers for the program-memory read-port arbiter.
//   state_e           : arbiter FSM states
//   owner_e           : requester identity (fetch / data)
//   DEFAULT_BASE_ADDR : byte address of word 0 of the program memory
//   addr_in_range()   : full-width range check of a byte address
package prog_mem_arb_pkg;

    localparam int unsigned ADDR_CHK_W = 64;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0000;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Callers zero-extend to ADDR_CHK_W bits, so the offset is never truncated
    // before the word-index compare.
    function automatic logic addr_in_range(input logic [ADDR_CHK_W-1:0] addr,
                                           input logic [ADDR_CHK_W-1:0] base,
                                           input int unsigned           depth);
        logic [ADDR_CHK_W-1:0] offs;
        offs = addr - base;
        return (addr >= base) && ((offs >> 2) < ADDR_CHK_W'(depth));
    endfunction

endpackage

// File: rtl/prog_mem_rr_arb2.sv
// Combinational two-way arbiter between fetch (F) and data (D) requesters.
//   req_f_i / req_d_i   : qualified requests
//   last_owner_i        : previous winner (round-robin build only)
//   gnt_f_c / gnt_d_c   : one-hot grant, combinational
// Build option: PROG_MEM_ARB_FIXED_PRIO_EN gives F strict priority on ties.
module prog_mem_rr_arb2
    import prog_mem_arb_pkg::*;
(
    input  logic   req_f_i,
    input  logic   req_d_i,
`ifndef PROG_MEM_ARB_FIXED_PRIO_EN
    input  owner_e last_owner_i,
`endif
    output logic   gnt_f_c,
    output logic   gnt_d_c
);

    // Pick the winner; on a tie either fixed F priority or the non-last owner.
    always_comb begin
        gnt_f_c = 1'b0;
        gnt_d_c = 1'b0;
`ifdef PROG_MEM_ARB_FIXED_PRIO_EN
        gnt_f_c = req_f_i;
        gnt_d_c = req_d_i & ~req_f_i;
`else
        if (req_f_i && req_d_i) begin
            gnt_f_c = (last_owner_i == OWN_D);
            gnt_d_c = (last_owner_i == OWN_F);
        end else begin
            gnt_f_c = req_f_i;
            gnt_d_c = req_d_i;
        end
`endif
    end

endmodule

// File: rtl/prog_mem_arbiter.sv
// Shares the program memory read port between instruction fetch (F) and a
// data/constant read path (D). Grant is combinational in the request cycle,
// memory address is presented the next cycle, data/valid follow one cycle later.
//   clk, reset (async, active low)
//   fetch_req_i/fetch_addr_i -> fetch_gnt_o, fetch_valid_o, fetch_data_o
//   data_req_i/data_addr_i   -> data_gnt_o, data_valid_o, data_data_o
//   mem_addr_o / mem_data_i  : program memory byte address / returned word
//   addr_err_o               : pulses with valid of a bad-address request
// Build option: PROG_MEM_ARB_FIXED_PRIO_EN (fixed F priority instead of round-robin).
module prog_mem_arbiter
    import prog_mem_arb_pkg::*;
#(
    parameter int unsigned            MEMORY_DEPTH = 64,
    parameter int unsigned            DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]  BASE_ADDR    = DATA_WIDTH'(DEFAULT_BASE_ADDR)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req_i,
    input  logic [DATA_WIDTH-1:0] fetch_addr_i,
    output logic                  fetch_gnt_o,
    output logic                  fetch_valid_o,
    output logic [DATA_WIDTH-1:0] fetch_data_o,
    input  logic                  data_req_i,
    input  logic [DATA_WIDTH-1:0] data_addr_i,
    output logic                  data_gnt_o,
    output logic                  data_valid_o,
    output logic [DATA_WIDTH-1:0] data_data_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  addr_err_o
);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
    logic [DATA_WIDTH-1:0] data_data_q, data_data_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic                  data_valid_q, data_valid_d;
    logic                  addr_err_q, addr_err_d;
`ifndef PROG_MEM_ARB_FIXED_PRIO_EN
    owner_e                last_owner_q, last_owner_d;
`endif

    logic                  idle_c;
    logic                  gnt_f_c, gnt_d_c;
    logic [DATA_WIDTH-1:0] sel_addr_c;
    logic                  sel_err_c;

    assign idle_c = (state_q == IDLE);

    // Requests are only visible to the arbiter in IDLE, so no grant in ACCESS.
    prog_mem_rr_arb2 u_arb (
        .req_f_i      (fetch_req_i & idle_c),
        .req_d_i      (data_req_i  & idle_c),
`ifndef PROG_MEM_ARB_FIXED_PRIO_EN
        .last_owner_i (last_owner_q),
`endif
        .gnt_f_c      (gnt_f_c),
        .gnt_d_c      (gnt_d_c)
    );

    // Winner's address and its range/alignment verdict.
    always_comb begin
        sel_addr_c = gnt_f_c ? fetch_addr_i : data_addr_i;
        sel_err_c  = (|sel_addr_c[1:0]) ||
                     !addr_in_range(ADDR_CHK_W'(sel_addr_c), ADDR_CHK_W'(BASE_ADDR), MEMORY_DEPTH);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        err_d         = err_q;
        mem_addr_d    = mem_addr_q;
        fetch_data_d  = fetch_data_q;
        data_data_d   = data_data_q;
        fetch_valid_d = 1'b0;
        data_valid_d  = 1'b0;
        addr_err_d    = 1'b0;
`ifndef PROG_MEM_ARB_FIXED_PRIO_EN
        last_owner_d  = last_owner_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_f_c || gnt_d_c) begin
                    state_d    = ACCESS;
                    owner_d    = gnt_f_c ? OWN_F : OWN_D;
                    err_d      = sel_err_c;
                    // Bad addresses never reach the memory; park on word 0.
                    mem_addr_d = sel_err_c ? BASE_ADDR : sel_addr_c;
`ifndef PROG_MEM_ARB_FIXED_PRIO_EN
                    last_owner_d = gnt_f_c ? OWN_F : OWN_D;
`endif
                end
            end
            ACCESS: begin
                state_d    = IDLE;
                addr_err_d = err_q;
                if (owner_q == OWN_F) begin
                    fetch_valid_d = 1'b1;
                    fetch_data_d  = err_q ? '0 : mem_data_i;
                end else begin
                    data_valid_d  = 1'b1;
                    data_data_d   = err_q ? '0 : mem_data_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            owner_q       <= OWN_F;
            err_q         <= 1'b0;
            mem_addr_q    <= BASE_ADDR;
            fetch_data_q  <= '0;
            data_data_q   <= '0;
            fetch_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;
            addr_err_q    <= 1'b0;
`ifndef PROG_MEM_ARB_FIXED_PRIO_EN
            last_owner_q  <= OWN_D;
`endif
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            err_q         <= err_d;
            mem_addr_q    <= mem_addr_d;
            fetch_data_q  <= fetch_data_d;
            data_data_q   <= data_data_d;
            fetch_valid_q <= fetch_valid_d;
            data_valid_q  <= data_valid_d;
            addr_err_q    <= addr_err_d;
`ifndef PROG_MEM_ARB_FIXED_PRIO_EN
            last_owner_q  <= last_owner_d;
`endif
        end
    end

    assign fetch_gnt_o   = gnt_f_c;
    assign data_gnt_o    = gnt_d_c;
    assign fetch_valid_o = fetch_valid_q;
    assign data_valid_o  = data_valid_q;
    assign fetch_data_o  = fetch_data_q;
    assign data_data_o   = data_data_q;
    assign mem_addr_o    = mem_addr_q;
    assign addr_err_o    = addr_err_q;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter. ROM word k holds 32'hA5A5_0000 | k.
module tb_prog_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req_i, data_req_i;
    logic [31:0] fetch_addr_i, data_addr_i;
    logic        fetch_gnt_o, fetch_valid_o, data_gnt_o, data_valid_o, addr_err_o;
    logic [31:0] fetch_data_o, data_data_o, mem_addr_o, mem_data_i;
    logic [31:0] rom_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_mem_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_req_i   (fetch_req_i),
        .fetch_addr_i  (fetch_addr_i),
        .fetch_gnt_o   (fetch_gnt_o),
        .fetch_valid_o (fetch_valid_o),
        .fetch_data_o  (fetch_data_o),
        .data_req_i    (data_req_i),
        .data_addr_i   (data_addr_i),
        .data_gnt_o    (data_gnt_o),
        .data_valid_o  (data_valid_o),
        .data_data_o   (data_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_i    (mem_data_i),
        .addr_err_o    (addr_err_o)
    );

    // Program memory model: combinational read.
    always_comb begin
        rom_idx = (mem_addr_o - 32'h0040_0000) >> 2;
        if (rom_idx < 32'd64) mem_data_i = 32'hA5A5_0000 | rom_idx;
        else                  mem_data_i = 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction: grant at N, address at N+1, valid at N+2.
    task automatic single(input logic is_f, input logic [31:0] addr,
                          input logic [31:0] exp_mem, input logic [31:0] exp_data,
                          input logic exp_err, input string tag);
        step();
        fetch_req_i = is_f;  fetch_addr_i = addr;
        data_req_i  = !is_f; data_addr_i  = addr;
        #4;
        check({tag, "_fgnt"}, 32'(fetch_gnt_o), 32'(is_f));
        check({tag, "_dgnt"}, 32'(data_gnt_o),  32'(!is_f));
        step();
        fetch_req_i = 1'b0; data_req_i = 1'b0;
        #4;
        check({tag, "_memaddr"}, mem_addr_o, exp_mem);
        check({tag, "_gnt_acc"}, 32'(fetch_gnt_o | data_gnt_o), 32'd0);
        step();
        #4;
        check({tag, "_fvalid"}, 32'(fetch_valid_o), 32'(is_f));
        check({tag, "_dvalid"}, 32'(data_valid_o),  32'(!is_f));
        check({tag, "_err"},    32'(addr_err_o),    32'(exp_err));
        check({tag, "_data"},   is_f ? fetch_data_o : data_data_o, exp_data);
    endtask

    initial begin
        logic        exp_f [4];
        logic [31:0] exp_word [4];

        reset = 1'b0;
        fetch_req_i = 1'b0; data_req_i = 1'b0;
        fetch_addr_i = '0;  data_addr_i = '0;
        #12;
        check("rst_memaddr", mem_addr_o, 32'h0040_0000);
        check("rst_flags", 32'({fetch_gnt_o, fetch_valid_o, data_gnt_o, data_valid_o, addr_err_o}), 32'd0);
        check("rst_fdata", fetch_data_o, 32'd0);
        check("rst_ddata", data_data_o, 32'd0);
        reset = 1'b1;

        // Continuous tie right after reset: F wins first.
`ifdef PROG_MEM_ARB_FIXED_PRIO_EN
        exp_f = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
        exp_f = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
        for (int k = 0; k < 4; k++) exp_word[k] = exp_f[k] ? 32'hA5A5_0000 : 32'hA5A5_0001;
        step();
        fetch_req_i = 1'b1; fetch_addr_i = 32'h0040_0000;
        data_req_i  = 1'b1; data_addr_i  = 32'h0040_0004;
        for (int k = 0; k < 4; k++) begin
            #4;
            check("tie_fgnt", 32'(fetch_gnt_o), 32'(exp_f[k]));
            check("tie_dgnt", 32'(data_gnt_o),  32'(!exp_f[k]));
            if (k > 0) begin
                check("tie_fvalid", 32'(fetch_valid_o), 32'(exp_f[k-1]));
                check("tie_dvalid", 32'(data_valid_o),  32'(!exp_f[k-1]));
                check("tie_data", exp_f[k-1] ? fetch_data_o : data_data_o, exp_word[k-1]);
            end
            step();
            #4;
            check("tie_gnt_acc", 32'(fetch_gnt_o | data_gnt_o), 32'd0);
            check("tie_memaddr", mem_addr_o, exp_f[k] ? 32'h0040_0000 : 32'h0040_0004);
            step();
            if (k == 3) begin
                fetch_req_i = 1'b0; data_req_i = 1'b0;
            end
        end
        #4;
        check("tie_last_valid", 32'({fetch_valid_o, data_valid_o}), exp_f[3] ? 32'd2 : 32'd1);
        check("tie_last_err", 32'(addr_err_o), 32'd0);

        single(1'b1, 32'h0040_0008, 32'h0040_0008, 32'hA5A5_0002, 1'b0, "fetch_w2");
        check("fetch_w2_no_dvalid", 32'(data_valid_o), 32'd0);
        single(1'b0, 32'h0040_0100, 32'h0040_0000, 32'd0, 1'b1, "d_range_hi");
        check("hold_fdata", fetch_data_o, 32'hA5A5_0002);
        single(1'b0, 32'h003F_FFFC, 32'h0040_0000, 32'd0, 1'b1, "d_range_lo");
        single(1'b0, 32'h0040_00FC, 32'h0040_00FC, 32'hA5A5_003F, 1'b0, "d_last_word");
        single(1'b1, 32'h0040_0002, 32'h0040_0000, 32'd0, 1'b1, "f_misalign");
        check("hold_ddata", data_data_o, 32'hA5A5_003F);

        // Reset in the ACCESS cycle drops the transaction.
        step();
        fetch_req_i = 1'b1; fetch_addr_i = 32'h0040_000C;
        #4;
        check("rstacc_gnt", 32'(fetch_gnt_o), 32'd1);
        step();
        fetch_req_i = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check("rstacc_memaddr", mem_addr_o, 32'h0040_0000);
        step();
        #4;
        check("rstacc_no_valid", 32'({fetch_valid_o, data_valid_o, addr_err_o}), 32'd0);
        check("rstacc_fdata", fetch_data_o, 32'd0);
        reset = 1'b1;
        step();
        fetch_req_i = 1'b1; fetch_addr_i = 32'h0040_0004;
        data_req_i  = 1'b1; data_addr_i  = 32'h0040_0008;
        #4;
        check("post_rst_fgnt", 32'(fetch_gnt_o), 32'd1);
        check("post_rst_dgnt", 32'(data_gnt_o), 32'd0);
        step();
        fetch_req_i = 1'b0; data_req_i = 1'b0;
        step();
        #4;
        check("post_rst_fvalid", 32'(fetch_valid_o), 32'd1);
        check("post_rst_fdata", fetch_data_o, 32'hA5A5_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
